i2s_rx_audio: RTL and testbench

I2S_RX_AUDIO -- requirements
Module: i2s_rx_audio

---
 rtl/i2s_rx_audio.sv | 190 +++++++++++++++++++
 tb/tb_i2s_rx_audio.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_audio.sv
// i2s_rx_audio
//   Receives a standard I2S stream (left slot with lrclk = 0, right slot with
//   lrclk = 1, MSB one bit after the lrclk edge) and presents each
//   left/right pair as parallel two's complement samples.
//   The bit clock, word select and data are asynchronous to clk_i. They are
//   synchronized first and only their synchronized copies are used.
//
// Parameters
//   WIDTH        sample width in bits (1..31)
//   SYNC_STAGES  synchronizer depth for sclk_i/lrclk_i/sdata_i (>= 2)
//
// Ports
//   clk_i    system clock, rising edge
//   rst_i    synchronous active-high reset
//   sclk_i   I2S bit clock (at most clk_i/4)
//   lrclk_i  I2S word select, 0 = left, 1 = right
//   sdata_i  I2S serial data, MSB first
//   left_o   last complete left sample
//   right_o  last complete right sample
//   valid_o  one-cycle pulse when a new left/right pair is presented
//   err_o    one-cycle pulse when a slot ends before WIDTH bits arrived
//
// Optional feature
//   I2S_RX_SLOT_ERR_EN  when defined, err_o reports truncated slots;
//                       otherwise err_o is tied to 0.
module i2s_rx_audio #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sclk_i,
  input  logic             lrclk_i,
  input  logic             sdata_i,
  output logic [WIDTH-1:0] left_o,
  output logic [WIDTH-1:0] right_o,
  output logic             valid_o,
  output logic             err_o
);

  localparam int CW = $clog2(WIDTH + 1);
  // The shift register only needs WIDTH-1 bits: the last bit of a word is
  // taken straight from the synchronized data line when the word is latched.
  localparam int SW = (WIDTH > 1) ? WIDTH - 1 : 1;

  typedef enum logic [1:0] {HUNT, SHIFT, PAD} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, lrclk_sync, sdata_sync;
  logic                   sclk_s, lrclk_s, sdata_s;
  logic                   sclk_prev, lrclk_prev;
  logic                   rise, lr_change;
  logic [CW-1:0]          bit_cnt;
  logic [SW-1:0]          shift_reg;
  logic [SW:0]            shift_ext;
  logic [WIDTH-1:0]       word, left_hold;
  logic                   channel, have_left, valid_pend;
  logic                   restart, shift_en, latch, trunc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      sclk_prev  <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk_i};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_i};
      sclk_prev  <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign lrclk_s   = lrclk_sync[SYNC_STAGES-1];
  assign sdata_s   = sdata_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_prev;
  assign lr_change = lrclk_s ^ lrclk_prev;
  assign shift_ext = {shift_reg, sdata_s};
  assign word      = shift_ext[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Every lrclk edge (seen on an sclk rise) starts a new slot and drops the
  // data bit of that rise, which is the one-bit I2S delay. Leaving SHIFT on
  // an edge means the slot was shorter than WIDTH bits.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    shift_en   = 1'b0;
    latch      = 1'b0;
    trunc      = 1'b0;
    if (rise) begin
      case (state)
        HUNT: begin
          if (lr_change) begin
            restart    = 1'b1;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (lr_change) begin
            restart    = 1'b1;
            trunc      = 1'b1;
            state_next = SHIFT;
          end else begin
            shift_en = 1'b1;
            if (bit_cnt == CW'(WIDTH - 1)) begin
              latch      = 1'b1;
              state_next = PAD;
            end
          end
        end
        PAD: begin
          if (lr_change) begin
            restart    = 1'b1;
            state_next = SHIFT;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // have_left marks a left word that is still waiting for its right partner.
  // It is dropped when a new left slot starts or any slot is truncated, so a
  // pair is only presented after a complete left followed by a complete right.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lrclk_prev <= 1'b0;
      channel    <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      left_hold  <= '0;
      have_left  <= 1'b0;
      left_o     <= '0;
      right_o    <= '0;
      valid_pend <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      valid_pend <= 1'b0;
      valid_o    <= valid_pend;
      if (rise) begin
        lrclk_prev <= lrclk_s;
      end
      if (restart) begin
        channel   <= lrclk_s;
        bit_cnt   <= '0;
        shift_reg <= '0;
        if (!lrclk_s || trunc) begin
          have_left <= 1'b0;
        end
      end else if (shift_en) begin
        shift_reg <= shift_ext[SW-1:0];
        bit_cnt   <= bit_cnt + CW'(1);
        if (latch) begin
          if (!channel) begin
            left_hold <= word;
            have_left <= 1'b1;
          end else if (have_left) begin
            left_o     <= left_hold;
            right_o    <= word;
            valid_pend <= 1'b1;
            have_left  <= 1'b0;
          end
        end
      end
    end
  end

`ifdef I2S_RX_SLOT_ERR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= trunc;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_audio.sv
// tb_i2s_rx_audio
//   Self-checking bench for i2s_rx_audio (WIDTH = 16, SYNC_STAGES = 2).
//   An I2S transmitter model drives the pins with sclk = clk/8; expected
//   left/right pairs go into a scoreboard queue when a frame is sent and are
//   popped and compared whenever valid_o pulses.
//   Honours I2S_RX_SLOT_ERR_EN for the expected err_o behaviour.
module tb_i2s_rx_audio;

`ifdef I2S_RX_SLOT_ERR_EN
  localparam int ERR_PER_TRUNC = 1;
`else
  localparam int ERR_PER_TRUNC = 0;
`endif

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        lrclk;
  logic        sdata;
  logic [15:0] left;
  logic [15:0] right;
  logic        valid;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int valid_count = 0;
  int err_count   = 0;

  logic [31:0] sb_q[$];

  i2s_rx_audio #(
    .WIDTH(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sclk_i(sclk),
    .lrclk_i(lrclk),
    .sdata_i(sdata),
    .left_o(left),
    .right_o(right),
    .valid_o(valid),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every valid_o pulse must match the oldest expected pair.
  always @(negedge clk) begin
    if (!rst && valid) begin
      valid_count++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_valid: got left=%h right=%h, required no valid_o", left, right);
      end else begin
        logic [31:0] exp_pair;
        exp_pair = sb_q.pop_front();
        if ({left, right} !== exp_pair) begin
          failures++;
          $display("[TB] FAIL pair: got left=%h right=%h, required left=%h right=%h",
                   left, right, exp_pair[31:16], exp_pair[15:0]);
        end
      end
    end
    if (!rst && err) err_count++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  // One I2S bit: data changes while sclk is low, receiver samples on rise.
  task automatic send_bit(input logic lr, input logic d);
    @(negedge clk);
    sclk  = 1'b0;
    lrclk = lr;
    sdata = d;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Slot of 'bits' bits; MSB of w goes out one bit after the lrclk edge.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int bits);
    for (int i = 0; i < bits; i++) begin
      if (i >= 1 && i <= 16) send_bit(lr, w[16-i]);
      else send_bit(lr, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int bits);
    send_slot(1'b0, l, bits);
    send_slot(1'b1, r, bits);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    sclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (left !== 16'h0 || right !== 16'h0 || valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got left=%h right=%h valid=%b err=%b, required all 0",
               left, right, valid, err);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mid_start;
    send_slot(1'b1, 16'hDEAD, 20);
    send_slot(1'b0, 16'h1111, 32);
    checks++;
    if (valid_count !== 0) begin
      failures++;
      $display("[TB] FAIL mid_start_no_valid: got %0d valid pulses, required 0", valid_count);
    end
    sb_q.push_back({16'h1111, 16'h2222});
    send_slot(1'b1, 16'h2222, 32);
    for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL mid_start_drain: got %0d pending pairs, required 0", sb_q.size());
    end
  endtask

  task automatic test_basic;
    int v0;
    v0 = valid_count;
    for (int f = 0; f < 3; f++) begin
      sb_q.push_back({16'hA5A5, 16'h5A5A});
      send_frame(16'hA5A5, 16'h5A5A, 32);
    end
    for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0 || valid_count - v0 != 3) begin
      failures++;
      $display("[TB] FAIL basic_count: got %0d pulses (%0d pending), required 3 (0 pending)",
               valid_count - v0, sb_q.size());
    end
  endtask

  task automatic test_back_to_back;
    sb_q.push_back({16'h8000, 16'h7FFF});
    send_frame(16'h8000, 16'h7FFF, 32);
    send_slot(1'b0, 16'h0001, 32);
    checks++;
    if (left !== 16'h8000 || right !== 16'h7FFF) begin
      failures++;
      $display("[TB] FAIL hold_after_left_latch: got left=%h right=%h, required left=8000 right=7fff",
               left, right);
    end
    sb_q.push_back({16'h0001, 16'hFFFF});
    send_slot(1'b1, 16'hFFFF, 32);
    for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL back_to_back_drain: got %0d pending pairs, required 0", sb_q.size());
    end
  endtask

  task automatic test_truncation;
    int v0;
    int e0;
    v0 = valid_count;
    e0 = err_count;
    send_slot(1'b0, 16'hABCD, 8);
    send_slot(1'b1, 16'h1234, 32);
    repeat (20) @(negedge clk);
    checks++;
    if (err_count - e0 != ERR_PER_TRUNC) begin
      failures++;
      $display("[TB] FAIL trunc_err: got %0d err pulses, required %0d", err_count - e0, ERR_PER_TRUNC);
    end
    checks++;
    if (valid_count != v0) begin
      failures++;
      $display("[TB] FAIL trunc_no_valid: got %0d valid pulses, required 0", valid_count - v0);
    end
    sb_q.push_back({16'h1357, 16'h2468});
    send_frame(16'h1357, 16'h2468, 32);
    for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL trunc_recover: got %0d pending pairs, required 0", sb_q.size());
    end
  endtask

  task automatic test_mid_reset;
    send_slot(1'b0, 16'h3333, 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (left !== 16'h0 || right !== 16'h0 || valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got left=%h right=%h valid=%b err=%b, required all 0",
               left, right, valid, err);
    end
    rst = 1'b0;
    send_slot(1'b0, 16'h3333, 22);
    send_slot(1'b1, 16'h4444, 32);
    sb_q.push_back({16'h0F0F, 16'hF0F0});
    send_frame(16'h0F0F, 16'hF0F0, 32);
    for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL mid_reset_frame: got %0d pending pairs, required 0", sb_q.size());
    end
  endtask

  task automatic test_slot17;
    int e0;
    e0 = err_count;
    for (int f = 0; f < 2; f++) begin
      sb_q.push_back({16'hFFFF, 16'h0000});
      send_frame(16'hFFFF, 16'h0000, 17);
    end
    for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL slot17_drain: got %0d pending pairs, required 0", sb_q.size());
    end
    checks++;
    if (err_count != e0) begin
      failures++;
      $display("[TB] FAIL slot17_err: got %0d err pulses, required 0", err_count - e0);
    end
  endtask

  initial begin
    test_reset();
    test_mid_start();
    test_basic();
    test_back_to_back();
    test_truncation();
    test_mid_reset();
    test_slot17();
    repeat (20) @(negedge clk);
    checks++;
    if (err_count != ERR_PER_TRUNC) begin
      failures++;
      $display("[TB] FAIL err_total: got %0d err pulses, required %0d", err_count, ERR_PER_TRUNC);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
